// File: rtl/connect4_pkg.sv
// Shared constants and types for the connect4 host sequencer.
package connect4_pkg;

    localparam int C4_COLS  = 7;
    localparam int C4_ROWS  = 6;
    localparam int C4_CELLS = 42;

    // Column index width; value 7 is the only out-of-range code.
    localparam int COL_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RE
    } host_state_t;

endpackage

// File: rtl/c4_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module c4_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, hold once every bit is set.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/connect4_host.sv
// Move sequencer for the connect4 engine: takes column choices, assigns the
// player, runs the op/re handshakes and keeps score.
// Optional watchdog enabled by defining C4H_TIMEOUT_EN.
module connect4_host
    import connect4_pkg::*;
#(
    parameter int SCORE_W     = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mv_valid,
    output logic               mv_ready,
    input  logic [2:0]         mv_col,
    input  logic               op_ready,
    output logic               op_valid,
    output logic               op_player_id,
    output logic [2:0]         op_col_id,
    output logic               re_ready,
    input  logic               re_valid,
    input  logic               re_err,
    input  logic               re_is_finished,
    input  logic               re_winner,
    input  logic               re_tie,
    output logic               cur_player,
    output logic [5:0]         move_cnt,
    output logic               game_done,
    output logic [SCORE_W-1:0] win0_cnt,
    output logic [SCORE_W-1:0] win1_cnt,
    output logic [SCORE_W-1:0] tie_cnt,
    output logic [SCORE_W-1:0] err_cnt,
    output logic               timeout
);

    localparam logic [5:0]       MOVE_MAX = 6'(C4_CELLS);
    localparam logic [COL_W-1:0] COL_BAD  = COL_W'(C4_COLS);

    host_state_t      state, state_nxt;
    logic             mv_ready_nxt, op_valid_nxt, op_player_nxt, re_ready_nxt;
    logic [COL_W-1:0] op_col_nxt;
    logic             cur_player_nxt, game_done_nxt;
    logic [5:0]       move_cnt_nxt;
    logic             win0_inc, win1_inc, tie_inc, err_inc;

    logic mv_fire, op_fire, re_fire;
    assign mv_fire = mv_valid & mv_ready;
    assign op_fire = op_valid & op_ready;
    assign re_fire = re_valid & re_ready;

    // Next-state, next-output and score strobes for the handshake sequencer.
    always_comb begin
        state_nxt      = state;
        mv_ready_nxt   = mv_ready;
        op_valid_nxt   = op_valid;
        op_player_nxt  = op_player_id;
        op_col_nxt     = op_col_id;
        re_ready_nxt   = re_ready;
        cur_player_nxt = cur_player;
        move_cnt_nxt   = move_cnt;
        game_done_nxt  = 1'b0;
        win0_inc       = 1'b0;
        win1_inc       = 1'b0;
        tie_inc        = 1'b0;
        err_inc        = 1'b0;
        case (state)
            S_IDLE: begin
                if (mv_fire) begin
                    if (mv_col == COL_BAD) begin
                        // Rejected locally; the engine never sees it.
                        err_inc = 1'b1;
                    end else begin
                        op_col_nxt    = mv_col;
                        op_player_nxt = cur_player;
                        mv_ready_nxt  = 1'b0;
                        op_valid_nxt  = 1'b1;
                        state_nxt     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (op_fire) begin
                    op_valid_nxt = 1'b0;
                    re_ready_nxt = 1'b1;
                    state_nxt    = S_WAIT_RE;
                end
            end
            S_WAIT_RE: begin
                if (re_fire) begin
                    re_ready_nxt = 1'b0;
                    mv_ready_nxt = 1'b1;
                    state_nxt    = S_IDLE;
                    if (re_err) begin
                        // Same player retries; error wins over finished.
                        err_inc = 1'b1;
                    end else if (re_is_finished) begin
                        game_done_nxt  = 1'b1;
                        cur_player_nxt = 1'b0;
                        move_cnt_nxt   = '0;
                        if (re_tie) begin
                            tie_inc = 1'b1;
                        end else if (re_winner) begin
                            win1_inc = 1'b1;
                        end else begin
                            win0_inc = 1'b1;
                        end
                    end else begin
                        if (move_cnt < MOVE_MAX) begin
                            move_cnt_nxt = move_cnt + 6'd1;
                        end
                        cur_player_nxt = ~cur_player;
                    end
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                mv_ready_nxt = 1'b1;
                op_valid_nxt = 1'b0;
                re_ready_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            mv_ready     <= 1'b1;
            op_valid     <= 1'b0;
            op_player_id <= 1'b0;
            op_col_id    <= '0;
            re_ready     <= 1'b0;
            cur_player   <= 1'b0;
            move_cnt     <= '0;
            game_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            mv_ready     <= mv_ready_nxt;
            op_valid     <= op_valid_nxt;
            op_player_id <= op_player_nxt;
            op_col_id    <= op_col_nxt;
            re_ready     <= re_ready_nxt;
            cur_player   <= cur_player_nxt;
            move_cnt     <= move_cnt_nxt;
            game_done    <= game_done_nxt;
        end
    end

    c4_sat_counter #(.WIDTH(SCORE_W)) u_win0 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(win0_inc), .count(win0_cnt)
    );
    c4_sat_counter #(.WIDTH(SCORE_W)) u_win1 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(win1_inc), .count(win1_cnt)
    );
    c4_sat_counter #(.WIDTH(SCORE_W)) u_tie (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(tie_inc), .count(tie_cnt)
    );
    c4_sat_counter #(.WIDTH(SCORE_W)) u_err (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(err_inc), .count(err_cnt)
    );

`ifdef C4H_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    // Watchdog: counts cycles spent in one busy state; flag is sticky and
    // does not disturb the FSM so it stays aligned with the engine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if ((state == S_IDLE) || (state_nxt != state)) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_W'(TIMEOUT_CYC)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if ((state != S_IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1))) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_connect4_host.sv
// Scoreboard bench for connect4_host: stimulus pushes expected op payloads
// and end-of-game scores; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_connect4_host;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mv_valid, mv_ready;
    logic [2:0] mv_col;
    logic       op_ready, op_valid, op_player_id;
    logic [2:0] op_col_id;
    logic       re_ready, re_valid, re_err, re_is_finished, re_winner, re_tie;
    logic       cur_player;
    logic [5:0] move_cnt;
    logic       game_done;
    logic [7:0] win0_cnt, win1_cnt, tie_cnt, err_cnt;
    logic       timeout;

    connect4_host #(.SCORE_W(8), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_col(mv_col),
        .op_ready(op_ready), .op_valid(op_valid),
        .op_player_id(op_player_id), .op_col_id(op_col_id),
        .re_ready(re_ready), .re_valid(re_valid), .re_err(re_err),
        .re_is_finished(re_is_finished), .re_winner(re_winner), .re_tie(re_tie),
        .cur_player(cur_player), .move_cnt(move_cnt), .game_done(game_done),
        .win0_cnt(win0_cnt), .win1_cnt(win1_cnt), .tie_cnt(tie_cnt),
        .err_cnt(err_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0]  op_q[$];    // {player, col}
    logic [23:0] game_q[$];  // {win0, win1, tie}
    logic        gd_prev = 1'b0;

`ifdef C4H_TIMEOUT_EN
    localparam logic EXP_TIMEOUT = 1'b1;
`else
    localparam logic EXP_TIMEOUT = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: op fires, game-end pulses, and handshake exclusivity.
    always @(negedge clk) begin
        if (rst_n) begin
            if (op_valid && op_ready) begin
                if (op_q.size() == 0) chk("unexpected_op", {28'd0, op_player_id, op_col_id}, 32'hFFFF);
                else chk("op_payload", {28'd0, op_player_id, op_col_id}, {28'd0, op_q.pop_front()});
            end
            if (game_done) begin
                if (game_q.size() == 0) chk("unexpected_game_done", 1, 0);
                else chk("game_scores", {8'd0, win0_cnt, win1_cnt, tie_cnt}, {8'd0, game_q.pop_front()});
                if (gd_prev) chk("game_done_width", 2, 1);
            end
            if (op_valid && re_ready) chk("op_re_overlap", 1, 0);
            gd_prev <= game_done;
        end else begin
            gd_prev <= 1'b0;
        end
    end

    // All tasks start and end at posedge+1.
    task automatic send_move(input logic [2:0] col, input logic player);
        int n = 0;
        while (!mv_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!mv_ready) chk("mv_ready_wait", 0, 1);
        if (col != 3'd7) op_q.push_back({player, col});
        mv_valid = 1'b1;
        mv_col   = col;
        @(posedge clk); #1;
        mv_valid = 1'b0;
    endtask

    task automatic respond(input logic err, input logic fin, input logic win,
                           input logic tie, input int delay,
                           input logic [23:0] exp_scores);
        int n = 0;
        while (!re_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!re_ready) chk("re_ready_wait", 0, 1);
        for (int i = 0; i < delay; i++) begin
            chk("re_ready_hold", re_ready, 1);
            @(posedge clk); #1;
        end
        if (!err && fin) game_q.push_back(exp_scores);
        re_valid = 1'b1; re_err = err; re_is_finished = fin;
        re_winner = win; re_tie = tie;
        @(posedge clk); #1;
        re_valid = 1'b0; re_err = 1'b0; re_is_finished = 1'b0;
        re_winner = 1'b0; re_tie = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_mv_ready"}, mv_ready, 1);
        chk({tag, "_op_bus"}, {op_valid, op_player_id, op_col_id, re_ready}, 0);
        chk({tag, "_turn"}, {cur_player, move_cnt, game_done}, 0);
        chk({tag, "_scores"}, {win0_cnt, win1_cnt, tie_cnt, err_cnt}, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        rst_n = 1'b0; mv_valid = 1'b0; mv_col = 3'd0; op_ready = 1'b1;
        re_valid = 1'b0; re_err = 1'b0; re_is_finished = 1'b0;
        re_winner = 1'b0; re_tie = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain move: op at +1, re_ready at +2, turn advances.
        send_move(3'd3, 1'b0);
        chk("op_valid_plus1", op_valid, 1);
        chk("re_ready_early", re_ready, 0);
        @(posedge clk); #1;
        chk("op_done_plus2", {op_valid, re_ready}, 2'b01);
        respond(0, 0, 0, 0, 0, 24'd0);
        chk("after_move1", {mv_ready, cur_player, move_cnt}, {1'b1, 1'b1, 6'd1});

        // Column 7: local reject.
        send_move(3'd7, 1'b0);
        chk("reject_err", err_cnt, 1);
        chk("reject_mv_ready", mv_ready, 1);
        @(posedge clk); #1;
        chk("reject_no_op", op_valid, 0);

        // Engine error: same player retries.
        send_move(3'd0, 1'b1);
        respond(1, 0, 0, 0, 0, 24'd0);
        chk("engerr_err", err_cnt, 2);
        chk("engerr_turn", {cur_player, move_cnt}, {1'b1, 6'd1});
        send_move(3'd0, 1'b1);
        respond(0, 0, 0, 0, 0, 24'd0);
        chk("retry_turn", {cur_player, move_cnt}, {1'b0, 6'd2});

        // Seven alternating moves, last one won by player 1.
        for (int i = 0; i < 6; i++) begin
            send_move(3'(i), 1'(i % 2));
            respond(0, 0, 0, 0, 0, 24'd0);
        end
        chk("pre_win_moves", {cur_player, move_cnt}, {1'b0, 6'd8});
        send_move(3'd6, 1'b0);
        respond(0, 1, 1, 0, 0, {8'd0, 8'd1, 8'd0});
        chk("win_pulse", game_done, 1);
        chk("win1_cnt", win1_cnt, 1);
        chk("win_turn_reset", {cur_player, move_cnt}, 0);
        @(posedge clk); #1;
        chk("win_pulse_end", game_done, 0);

        // Tie game.
        send_move(3'd6, 1'b0);
        respond(0, 1, 0, 1, 0, {8'd0, 8'd1, 8'd1});
        chk("tie_cnt", tie_cnt, 1);

        // Player 0 wins.
        send_move(3'd1, 1'b0);
        respond(0, 0, 0, 0, 0, 24'd0);
        send_move(3'd2, 1'b1);
        respond(0, 1, 0, 0, 0, {8'd1, 8'd1, 8'd1});
        chk("win0_cnt", win0_cnt, 1);
        chk("win0_turn_reset", {cur_player, move_cnt}, 0);

        // Error together with finished: error wins.
        send_move(3'd4, 1'b0);
        respond(1, 1, 1, 0, 0, 24'd0);
        chk("errfin_err", err_cnt, 3);
        chk("errfin_no_done", game_done, 0);
        chk("errfin_scores", {win0_cnt, win1_cnt, tie_cnt}, {8'd1, 8'd1, 8'd1});

        // Back-pressure on op, delayed response.
        op_ready = 1'b0;
        send_move(3'd5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("stall_payload", {op_valid, op_player_id, op_col_id, re_ready},
                {1'b1, 1'b0, 3'd5, 1'b0});
            @(posedge clk); #1;
        end
        op_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", {op_valid, re_ready}, 2'b01);
        respond(0, 0, 0, 0, 5, 24'd0);
        chk("stall_turn", {cur_player, move_cnt}, {1'b1, 6'd1});
        chk("timeout_flag", timeout, EXP_TIMEOUT);

        // Error counter saturation.
        for (int i = 0; i < 252; i++) send_move(3'd7, 1'b0);
        chk("err_reach_max", err_cnt, 255);
        for (int i = 0; i < 3; i++) send_move(3'd7, 1'b0);
        chk("err_saturated", err_cnt, 255);

        // Reset while waiting for a response.
        send_move(3'd2, 1'b1);
        @(posedge clk); #1;
        chk("in_wait_re", re_ready, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_reset_state("midrst");
        @(posedge clk); #1;
        chk("post_rst_quiet", {op_valid, re_ready}, 0);

        // Recovery after reset.
        send_move(3'd3, 1'b0);
        respond(0, 0, 0, 0, 0, 24'd0);
        chk("recover_turn", {cur_player, move_cnt}, {1'b1, 6'd1});

        repeat (2) @(posedge clk); #1;
        chk("op_q_drained", op_q.size(), 0);
        chk("game_q_drained", game_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout: sim did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/connect4_host.md
Name: connect4_host

Overview:
- Initiator-side move sequencer for the connect4 game engine.
- Accepts a stream of column choices from upstream (keypad/testbench/AI), assigns the player ID itself, and drives the engine's op_* request channel.
- Consumes the engine's re_* response channel, advances turns, and keeps per-game and cumulative score statistics.
- Sits between the move source and the connect4 engine; the engine is the only consumer of its op_* outputs.

Parameters:
- SCORE_W, 8: width of win/tie/error counters; counters saturate at all-ones.
- TIMEOUT_CYC, 64: watchdog limit in cycles; used only with C4H_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mv_valid  in  1  upstream move present.
- mv_ready  out  1  host can accept a move.
- mv_col  in  3  requested column; 0..6 legal.
- op_ready  in  1  engine can accept an op.
- op_valid  out  1  op request valid.
- op_player_id  out  1  player for this op.
- op_col_id  out  3  column for this op.
- re_ready  out  1  host can accept a response.
- re_valid  in  1  engine response valid.
- re_err  in  1  engine rejected the move (full column).
- re_is_finished  in  1  game ended.
- re_winner  in  1  winner ID when finished and not tie.
- re_tie  in  1  board full, no winner.
- cur_player  out  1  player whose turn it is.
- move_cnt  out  6  accepted moves in the current game, 0..42.
- game_done  out  1  one-cycle pulse when a game ends.
- win0_cnt, win1_cnt, tie_cnt, err_cnt  out  SCORE_W each  cumulative statistics.
- timeout  out  1  sticky watchdog flag; tied 0 without the macro.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=S_IDLE, mv_ready=1.
  - op_valid=0, op_player_id=0, op_col_id=0, re_ready=0.
  - cur_player=0, move_cnt=0, game_done=0, all counters=0, timeout=0.
- Reset mid-transaction abandons the transaction with no further handshakes. The engine is expected to share the same reset.
- All outputs are registered.
- States: S_IDLE, S_ISSUE, S_WAIT_RE.
- S_IDLE:
  - mv_ready=1.
  - On mv_valid&mv_ready with mv_col<=6: latch op_col_id=mv_col and op_player_id=cur_player, mv_ready<=0, op_valid<=1, go to S_ISSUE. op_valid is visible the cycle after the move fire.
  - On mv_col==7: local reject. err_cnt increments, no op is issued, stay in S_IDLE with mv_ready=1.
- S_ISSUE:
  - op_valid held at 1 with payload stable until op_ready=1.
  - On op fire: op_valid<=0, re_ready<=1, go to S_WAIT_RE.
- S_WAIT_RE:
  - re_ready held at 1 until re_valid=1.
  - On re fire: re_ready<=0, mv_ready<=1, go to S_IDLE, and apply exactly one of the following:
  - re_err=1: err_cnt++; cur_player and move_cnt unchanged, so the same player retries.
  - re_is_finished=1 and re_tie=1: tie_cnt++; game_done pulse; cur_player<=0, move_cnt<=0.
  - re_is_finished=1 and re_tie=0: win0_cnt++ or win1_cnt++ selected by re_winner; game_done pulse; cur_player<=0, move_cnt<=0.
  - Otherwise: move_cnt++ and cur_player toggles.
- Timing: minimum round trip is move fire → op_valid at +1 → (op_ready already high) re_ready at +2. Statistics update and mv_ready=1 appear the cycle after re fire.
- The host never asserts op_valid and re_ready in the same cycle.
- Counters saturate; a saturated counter stays at all-ones and does not wrap.
- re_err combined with re_is_finished is treated as an error: the error branch has priority.

Optional Feature:
- Macro C4H_TIMEOUT_EN.
- When defined:
  - A counter runs while in S_ISSUE or S_WAIT_RE and clears on each state entry.
  - Reaching TIMEOUT_CYC sets timeout=1 (sticky until reset).
  - The FSM does not change state, to avoid desynchronising from the engine.
- When undefined: no counter is built and timeout is tied to 0.

Decomposition:
- Package connect4_pkg holds:
  - constants C4_COLS=7, C4_ROWS=6, C4_CELLS=42;
  - the host state enum;
  - the column width localparam.
- One sub-module, c4_sat_counter (width parameter, inc input, clear input), instantiated four times for the win/tie/error counters.

Test Plan:
- Reset, then move col=3 with op_ready=1 → op_valid at +1 with player=0, col=3. Respond re_err=0, finished=0 → cur_player=1, move_cnt=1.
- Move col=7 → no op_valid; err_cnt=1; mv_ready stays 1.
- Engine response re_err=1 on col=0 → err_cnt++, cur_player unchanged; the next move is issued with the same player ID.
- Seven alternating moves ending with re_is_finished=1, re_winner=1 → win1_cnt=1, one-cycle game_done, cur_player=0, move_cnt=0.
- Hold op_ready=0 for 10 cycles, then re_valid delayed 5 cycles → op_valid and payload stable throughout; re_ready=1 only after op fire. With C4H_TIMEOUT_EN and TIMEOUT_CYC=8, timeout=1 is asserted.
- Assert rst_n=0 in S_WAIT_RE → next cycle all outputs at reset values and mv_ready=1.
